// File: rtl/r4_ifft_seq.sv
// Sequential radix-4 inverse butterfly (twiddle +j, unscaled): takes one block of
// four complex samples, streams y0..y3 out one beat per output handshake.
module r4_ifft_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] xr0,
  input  logic [WIDTH-1:0] xi0,
  input  logic [WIDTH-1:0] xr1,
  input  logic [WIDTH-1:0] xi1,
  input  logic [WIDTH-1:0] xr2,
  input  logic [WIDTH-1:0] xi2,
  input  logic [WIDTH-1:0] xr3,
  input  logic [WIDTH-1:0] xi3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] yr,
  output logic [WIDTH-1:0] yi,
  output logic [1:0]       out_idx,
  output logic             out_last
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t state, state_nxt;

  logic [3:0][WIDTH-1:0] cap_r, cap_i;
  logic [3:0][WIDTH-1:0] in_r, in_i;
  logic [3:0][WIDTH-1:0] src_r, src_i;
  logic [3:0][WIDTH-1:0] res_r, res_i;
  logic                  in_hs, out_hs;
  logic [1:0]            idx_inc;

  assign in_r = {xr3, xr2, xr1, xr0};
  assign in_i = {xi3, xi2, xi1, xi0};

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == EMIT);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign idx_inc   = out_idx + 2'd1;

  // In IDLE y0 is loaded straight from the ports on the capture edge; during
  // EMIT every later result comes from the captured block.
  assign src_r = (state == IDLE) ? in_r : cap_r;
  assign src_i = (state == IDLE) ? in_i : cap_i;

  // WIDTH-bit adders wrap naturally, giving the required mod 2^WIDTH result.
  assign res_r[0] = src_r[0] + src_r[1] + src_r[2] + src_r[3];
  assign res_i[0] = src_i[0] + src_i[1] + src_i[2] + src_i[3];
  assign res_r[1] = src_r[0] - src_i[1] - src_r[2] + src_i[3];
  assign res_i[1] = src_i[0] + src_r[1] - src_i[2] - src_r[3];
  assign res_r[2] = src_r[0] - src_r[1] + src_r[2] - src_r[3];
  assign res_i[2] = src_i[0] - src_i[1] + src_i[2] - src_i[3];
  assign res_r[3] = src_r[0] + src_i[1] - src_r[2] - src_i[3];
  assign res_i[3] = src_i[0] - src_r[1] - src_i[2] + src_r[3];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_hs) state_nxt = EMIT;
      EMIT: if (out_hs && out_idx == 2'd3) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_r    <= '0;
      cap_i    <= '0;
      yr       <= '0;
      yi       <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
    end else if (in_hs) begin
      cap_r    <= in_r;
      cap_i    <= in_i;
      yr       <= res_r[0];
      yi       <= res_i[0];
      out_idx  <= 2'd0;
      out_last <= 1'b0;
    end else if (out_hs) begin
      if (out_idx != 2'd3) begin
        yr       <= res_r[idx_inc];
        yi       <= res_i[idx_inc];
        out_idx  <= idx_inc;
        out_last <= (idx_inc == 2'd3);
      end else begin
        out_idx  <= 2'd0;
        out_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_r4_ifft_seq.sv
// Scoreboard bench for r4_ifft_seq: a DFT-style reference model (sum of x[n]*j^(n*k))
// feeds an expected-beat queue; a negedge monitor pops and compares accepted beats.
module tb_r4_ifft_seq;
  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] i;
    logic [1:0]   idx;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] xr [4];
  logic [W-1:0] xi [4];
  logic         in_ready, out_valid, out_last;
  logic [W-1:0] yr, yi;
  logic [1:0]   out_idx;

  r4_ifft_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .xr0(xr[0]), .xi0(xi[0]), .xr1(xr[1]), .xi1(xi[1]),
    .xr2(xr[2]), .xi2(xi[2]), .xr3(xr[3]), .xi3(xi[3]),
    .out_valid(out_valid), .out_ready(out_ready),
    .yr(yr), .yi(yi), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    last_neg = -100;
  int    acc_neg = 0;
  bit    rnd_rdy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Inverse DFT point k: y[k] = sum_n x[n] * j^(n*k), reduced mod 2^W.
  function automatic beat_t ref_beat(input int ar[4], input int ai[4], input int k);
    beat_t b;
    int sr, si;
    sr = 0; si = 0;
    for (int n = 0; n < 4; n++) begin
      case ((n * k) % 4)
        0: begin sr += ar[n]; si += ai[n]; end
        1: begin sr -= ai[n]; si += ar[n]; end
        2: begin sr -= ar[n]; si -= ai[n]; end
        default: begin sr += ai[n]; si -= ar[n]; end
      endcase
    end
    b.r    = sr[W-1:0];
    b.i    = si[W-1:0];
    b.idx  = k[1:0];
    b.last = (k == 3);
    return b;
  endfunction

  // Monitor: compares every accepted beat against the queue head, and checks
  // that a stalled beat holds steady.
  beat_t prev;
  bit    prev_hold = 1'b0;
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      if (out_valid) chk("in_ready_low_in_emit", in_ready, 0);
      if (out_valid && prev_hold) begin
        chk("hold_yr", yr, prev.r);
        chk("hold_yi", yi, prev.i);
        chk("hold_idx", out_idx, prev.idx);
      end
      prev_hold = out_valid && !out_ready;
      prev = {yr, yi, out_idx, out_last};
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          e = q.pop_front();
          chk("yr", yr, e.r);
          chk("yi", yi, e.i);
          chk("out_idx", out_idx, e.idx);
          chk("out_last", out_last, e.last);
          if (out_last) last_neg = cyc;
        end
      end
    end else prev_hold = 1'b0;
  end

  initial forever begin
    @(posedge clk); #1;
    if (rnd_rdy) out_ready = ($urandom % 4) != 0;
  end

  // Called at posedge+#1; returns at posedge+#1 just after the input handshake.
  task automatic send(input int ar[4], input int ai[4], input bit keep);
    bit got;
    for (int n = 0; n < 4; n++) begin
      xr[n] = ar[n][W-1:0];
      xi[n] = ai[n][W-1:0];
    end
    in_valid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 80 && !got; t++) begin
      @(negedge clk);
      got = in_ready;
    end
    if (!got) begin
      chk("in_accept_timeout", 0, 1);
      in_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    acc_neg = cyc;
    for (int k = 0; k < 4; k++) q.push_back(ref_beat(ar, ai, k));
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      xr[n] = W'($urandom);
      xi[n] = W'($urandom);
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 400 && q.size() > 0; t++) @(negedge clk);
    chk("drain_queue_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic rand_block(output int ar[4], output int ai[4]);
    for (int n = 0; n < 4; n++) begin
      ar[n] = $urandom_range(0, 15);
      ai[n] = $urandom_range(0, 15);
    end
  endtask

  initial begin
    int a_r[4], a_i[4], b_r[4], b_i[4];
    int a_acc;
    bit keep;
    for (int n = 0; n < 4; n++) begin xr[n] = '0; xi[n] = '0; end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_yr", yr, 0);
    chk("rst_yi", yi, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    @(posedge clk); #1;

    // Impulse at x0: four identical beats on consecutive cycles
    out_ready = 1'b1;
    a_r = '{1, 0, 0, 0}; a_i = '{0, 0, 0, 0};
    send(a_r, a_i, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("impulse_valid", out_valid, 1);
      chk("impulse_idx", out_idx, k);
    end
    @(posedge clk); #1;
    wait_drain();

    // Direction: x1 impulse must rotate by +j
    a_r = '{0, 1, 0, 0}; a_i = '{0, 0, 0, 0};
    send(a_r, a_i, 1'b0);
    wait_drain();

    // Wrap-around
    a_r = '{5, 5, 5, 5}; a_i = '{0, 0, 0, 0};
    send(a_r, a_i, 1'b0);
    wait_drain();

    // Backpressure with y1 pending
    rand_block(a_r, a_i);
    send(a_r, a_i, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idx_still_1", out_idx, 1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_advance_idx_2", out_idx, 2);
    wait_drain();

    // Back-to-back with in_valid held; B's data sits on the ports during A's emission
    rand_block(a_r, a_i);
    rand_block(b_r, b_i);
    send(a_r, a_i, 1'b1);
    a_acc = acc_neg;
    send(b_r, b_i, 1'b0);
    chk("b2b_gap_after_last", acc_neg - last_neg, 1);
    chk("b2b_period", acc_neg - a_acc, 5);
    wait_drain();

    // Reset after y1 accepted
    rand_block(a_r, a_i);
    send(a_r, a_i, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_yr", yr, 0);
    chk("midrst_yi", yi, 0);
    chk("midrst_idx", out_idx, 0);
    chk("midrst_last", out_last, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    rand_block(a_r, a_i);
    send(a_r, a_i, 1'b0);
    wait_drain();

    // Randomized blocks with random consumer stalls
    rnd_rdy = 1'b1;
    for (int b = 0; b < 40; b++) begin
      rand_block(a_r, a_i);
      keep = (b != 39) && ($urandom % 2 == 1);
      send(a_r, a_i, keep);
      if (!keep) repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_drain();
    rnd_rdy = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
